vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA sync and timing generator. It divides the system clock into a pixel tick and runs horizontal and vertical counters over a programmable display, porch and sync geometry. From these it produces hsync, vsync, video_on and pixel coordinates, plus line and frame start strobes. It sits between the system clock and the pixel/character renderers and generalises the fixed 640x480 sync generator to any mode, tick ratio and sync polarity.

## Interface
Parameters:
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BACK, 48: horizontal back porch, in pixels
- V_DISPLAY, 480: visible lines
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BACK, 33: vertical back porch, in lines
- TICK_DIV, 4: clk cycles per pixel, ≥1 (100 MHz clk gives 25 MHz pixel rate)
- HS_POL, 0: hsync active level (0 = active-low)
- VS_POL, 0: vsync active level
- CW, 10: counter/coordinate width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run when high; freeze when low
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- video_on  out  1  high while pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- p_tick  out  1  one-clk pulse once per pixel period
- pixel_x  out  CW  current column
- pixel_y  out  CW  current line
- line_start  out  1  one-clk pulse when pixel_x becomes 0
- frame_start  out  1  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)

## Operation
- Derived values: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL likewise (525 by default).
- Elaboration error if H_TOTAL > 2^CW, V_TOTAL > 2^CW, or TICK_DIV < 1.
- Divider: div counts 0..TICK_DIV-1 and wraps. p_tick is high in the cycle where div == TICK_DIV-1. If TICK_DIV = 1, p_tick is held high while enabled.
- Counter update on the clock edge closing a p_tick cycle:
  - pixel_x increments.
  - At H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments.
  - At pixel_y == V_TOTAL-1 with a line wrap, pixel_y wraps to 0.
- Decode, all from the same count:
  - hsync is active for pixel_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vsync is active for pixel_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- hsync, vsync, video_on, line_start and frame_start are registered from next-state counts, so they have zero skew to pixel_x/pixel_y.
- enable low: div, counters and all levels hold; p_tick, line_start and frame_start are forced to 0. Counting resumes from the held state with no skipped pixel.
- Reset (asynchronous, reset = 0):
  - div = 0, pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1.
  - hsync = !HS_POL, vsync = !VS_POL.
  - video_on, p_tick, line_start and frame_start = 0.
  - The first pixel advance after release therefore lands on (0,0) with frame_start.
- Reset asserted mid-frame forces the reset values immediately, with no waiting for a tick.

## Timing
- After reset release with enable high, p_tick first asserts in clk cycle TICK_DIV (cycles counted from 1).
- The counters reach (0,0) on the next edge. frame_start and line_start are high for the one clk cycle after that edge.
- pixel_x holds each value for exactly TICK_DIV clk cycles while enabled.
- Line period = H_TOTAL·TICK_DIV clk cycles; frame period = V_TOTAL·H_TOTAL·TICK_DIV clk cycles.
- hsync asserts H_DISPLAY+H_FRONT pixel periods after line_start and lasts H_SYNC pixel periods. vsync lasts V_SYNC full lines.
- When pixel_x wraps on the last line, pixel_y changes on the same edge as pixel_x. The vertical strobes and levels update in that cycle as well.

## Structure
- Package vga_timing_pkg holds:
  - Default mode constants for 640x480@60: H_DISPLAY/H_FRONT/H_SYNC/H_BACK and V_DISPLAY/V_FRONT/V_SYNC/V_BACK.
  - The equivalent set for 800x600@72.
  - The H_TOTAL/V_TOTAL helper functions.
- Sub-module pixel_tick_div (TICK_DIV, enable, p_tick) owns the divider. Counters, decode and output registers stay in vga_timing_gen.

## Test plan
- Defaults, clk period 10 ns, reset released at 100 ns → p_tick first rises 4 cycles later. frame_start pulses with pixel_x = 0, pixel_y = 0. Consecutive frame_start pulses are 1,680,000 clk cycles apart.
- Within a line → video_on high for pixel_x 0..639. hsync low exactly for pixel_x 656..751. Each pixel lasts 4 clk cycles.
- Within a frame → vsync low for pixel_y 490..491. 525 line_start pulses per frame. pixel_y wraps 524→0 on the same edge that pixel_x wraps 799→0.
- TICK_DIV = 1, HS_POL = 1, 800x600@72 constants → p_tick constantly high. hsync high for pixel_x 856..975. Line length 1040 clk cycles.
- enable dropped for 37 cycles at pixel_x = 300 → pixel_x holds 300 and no strobes fire. The line completes 37 cycles late with no skipped pixel.
- reset pulsed at (pixel_x 400, pixel_y 200) → outputs go to 799, 524, inactive sync, video_on = 0 within the same cycle. The frame restarts cleanly after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Mode constants and geometry helpers shared by the VGA timing generator.
package vga_timing_pkg;

  // 640x480@60, 25 MHz pixel clock
  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  // 800x600@72, 50 MHz pixel clock
  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 56;
  localparam int SVGA800_H_SYNC    = 120;
  localparam int SVGA800_H_BACK    = 64;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_FRONT   = 37;
  localparam int SVGA800_V_SYNC    = 6;
  localparam int SVGA800_V_BACK    = 23;

  function automatic int h_total(input int display, input int front,
                                 input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int v_total(input int display, input int front,
                                 input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock into a one-cycle pixel tick every TICK_DIV cycles.
module pixel_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic p_tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // Gated by reset so that a divide-by-one tick stays low while held in reset.
  assign p_tick = reset & enable & (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA sync/timing generator: pixel counters, sync decode and
// strobes, all registered from the next-state counts so they stay aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA640_H_DISPLAY,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_DISPLAY = VGA640_V_DISPLAY,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter int TICK_DIV  = 4,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          p_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW) || TICK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: geometry does not fit CW or TICK_DIV < 1");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic          x_last;
  logic          y_last;
  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          line_start_q;
  logic          frame_start_q;

  pixel_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .p_tick (p_tick)
  );

  always_comb begin
    x_last = (pixel_x == H_LAST);
    y_last = (pixel_y == V_LAST);
    next_x = x_last ? '0 : pixel_x + 1'b1;
    next_y = pixel_y;
    if (x_last) begin
      next_y = y_last ? '0 : pixel_y + 1'b1;
    end
  end

  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x       <= H_LAST;
      pixel_y       <= V_LAST;
      hsync         <= ~HS_POL;
      vsync         <= ~VS_POL;
      video_on      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (p_tick) begin
      pixel_x       <= next_x;
      pixel_y       <= next_y;
      hsync         <= (next_x >= HS_START && next_x <= HS_END) ? HS_POL : ~HS_POL;
      vsync         <= (next_y >= VS_START && next_y <= VS_END) ? VS_POL : ~VS_POL;
      video_on      <= (next_x < H_VIS) && (next_y < V_VIS);
      line_start_q  <= x_last;
      frame_start_q <= x_last & y_last;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  // Strobes drop at once when the generator is frozen.
  assign line_start  = line_start_q & enable;
  assign frame_start = frame_start_q & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries driven in lockstep against a
// tick-count reference model, plus targeted period and pulse-width checks.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int N = 3;
  localparam int OW = 28;
  localparam int W = N * OW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  // u0: defaults; u1: 800x600 divide-by-one, hsync active-high; u2: tiny frame
  logic hs0, vs0, vo0, pt0, ls0, fs0;
  logic [9:0] x0, y0;
  logic hs1, vs1, vo1, pt1, ls1, fs1;
  logic [10:0] x1, y1;
  logic hs2, vs2, vo2, pt2, ls2, fs2;
  logic [3:0] x2, y2;

  vga_timing_gen u0 (
    .clk(clk), .reset(reset), .enable(enable), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .p_tick(pt0), .pixel_x(x0), .pixel_y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_DISPLAY(SVGA800_H_DISPLAY), .H_FRONT(SVGA800_H_FRONT),
    .H_SYNC(SVGA800_H_SYNC), .H_BACK(SVGA800_H_BACK),
    .V_DISPLAY(SVGA800_V_DISPLAY), .V_FRONT(SVGA800_V_FRONT),
    .V_SYNC(SVGA800_V_SYNC), .V_BACK(SVGA800_V_BACK),
    .TICK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(11)
  ) u1 (
    .clk(clk), .reset(reset), .enable(enable), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .p_tick(pt1), .pixel_x(x1), .pixel_y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .TICK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b1), .CW(4)
  ) u2 (
    .clk(clk), .reset(reset), .enable(enable), .hsync(hs2), .vsync(vs2),
    .video_on(vo2), .p_tick(pt2), .pixel_x(x2), .pixel_y(y2),
    .line_start(ls2), .frame_start(fs2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: everything follows from the number of enabled edges since release.
  function automatic logic [OW-1:0] model_out(input int i, input int ev, input bit rst,
                                              input bit en, input bit cnt);
    int t, hd, hf, hw, hb, vd, vf, vw, vb, ht, vt, p, x, y;
    bit hp, vp, tk, pt, hs_on, vs_on, vo;
    case (i)
      0:       begin t = 4; hd = 640; hf = 16; hw = 96;  hb = 48; vd = 480; vf = 10; vw = 2; vb = 33; hp = 0; vp = 0; end
      1:       begin t = 1; hd = 800; hf = 56; hw = 120; hb = 64; vd = 600; vf = 37; vw = 6; vb = 23; hp = 1; vp = 0; end
      default: begin t = 2; hd = 8;   hf = 2;  hw = 3;   hb = 2;  vd = 4;   vf = 1;  vw = 2; vb = 1;  hp = 0; vp = 1; end
    endcase
    ht = hd + hf + hw + hb;
    vt = vd + vf + vw + vb;
    p = (ev / t + ht * vt - 1) % (ht * vt);
    x = p % ht;
    y = p / ht;
    tk = rst && en && cnt && (ev > 0) && (ev % t == 0);
    pt = rst && en && (ev % t == t - 1);
    hs_on = (x >= hd + hf) && (x < hd + hf + hw);
    vs_on = (y >= vd + vf) && (y < vd + vf + vw);
    vo = (x < hd) && (y < vd);
    return {hs_on ? hp : ~hp, vs_on ? vp : ~vp, vo, pt, tk && (x == 0),
            tk && (x == 0) && (y == 0), 11'(x), 11'(y)};
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] ent;
  bit cur_rst = 1'b0;
  bit cur_en = 1'b0;
  bit last_cnt = 1'b0;
  int ev = 0;
  int rel = 0;
  int cyc = 0;

  // One clock of stimulus: account for the edge just taken, then drive and predict.
  task automatic step(input bit rst, input bit en);
    @(posedge clk);
    last_cnt = cur_rst && cur_en;
    if (last_cnt) ev++;
    #1;
    reset = rst;
    enable = en;
    cur_rst = rst;
    cur_en = en;
    if (!rst) begin
      ev = 0;
      last_cnt = 1'b0;
      rel = 0;
    end else begin
      rel++;
    end
    cyc++;
    exp_q.push_back({model_out(0, ev, rst, en, last_cnt), model_out(1, ev, rst, en, last_cnt),
                     model_out(2, ev, rst, en, last_cnt)});
  endtask

  int first_pt0 = 0;
  int first_fs0 = 0;
  int hs0_cnt = 0;
  int vo0_cnt = 0;
  int ls2_cnt = 0;
  int vs2_cnt = 0;
  int ls0_t[$];
  int ls1_t[$];
  int fs2_t[$];
  int ls2_at[$];
  int vs2_at[$];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      check_eq("u0_out", {4'b0, hs0, vs0, vo0, pt0, ls0, fs0, 11'(x0), 11'(y0)}, {4'b0, ent[83:56]});
      check_eq("u1_out", {4'b0, hs1, vs1, vo1, pt1, ls1, fs1, x1, y1}, {4'b0, ent[55:28]});
      check_eq("u2_out", {4'b0, hs2, vs2, vo2, pt2, ls2, fs2, 11'(x2), 11'(y2)}, {4'b0, ent[27:0]});
      if (pt0 && first_pt0 == 0) first_pt0 = rel;
      if (fs0 && first_fs0 == 0) first_fs0 = rel;
      if (ls0) ls0_t.push_back(cyc);
      if (ls0_t.size() == 1) begin
        if (!hs0) hs0_cnt++;
        if (vo0) vo0_cnt++;
      end
      if (ls1) ls1_t.push_back(cyc);
      if (ls2) ls2_cnt++;
      if (vs2) vs2_cnt++;
      if (fs2) begin
        fs2_t.push_back(cyc);
        ls2_at.push_back(ls2_cnt);
        vs2_at.push_back(vs2_cnt);
      end
    end
  end

  function automatic int diff_at(input int q[$], input int k);
    return (q.size() > k) ? q[k] - q[k-1] : -1;
  endfunction

  bit found;

  initial begin
    #1 reset = 1'b0;
    #1;
    check_eq("rst_x", 32'(x0), 799);
    check_eq("rst_y", 32'(y0), 524);
    check_eq("rst_hsync", 32'(hs0), 1);
    check_eq("rst_vsync", 32'(vs0), 1);
    check_eq("rst_video_on", 32'(vo0), 0);
    check_eq("rst_ptick_div1", 32'(pt1), 0);
    check_eq("rst_hsync_pol1", 32'(hs1), 0);

    repeat (9) step(1'b0, 1'b1);
    repeat (3300) step(1'b1, 1'b1);
    check_eq("first_ptick_cycle", first_pt0, 4);
    check_eq("first_frame_start_cycle", first_fs0, 5);
    check_eq("hsync_cycles_per_line", hs0_cnt, 384);
    check_eq("video_on_cycles_per_line", vo0_cnt, 2560);
    check_eq("u0_line_period", diff_at(ls0_t, 1), 3200);
    check_eq("u1_line_period", diff_at(ls1_t, 1), 1040);
    check_eq("u2_frame_period", diff_at(fs2_t, 2), 240);
    check_eq("u2_lines_per_frame", diff_at(ls2_at, 2), 8);
    check_eq("u2_vsync_cycles", diff_at(vs2_at, 2), 60);

    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      step(1'b1, 1'b1);
      if (x0 == 10'd300 && y0 == 10'd1) found = 1'b1;
    end
    check_eq("reach_x300", 32'(found), 1);
    repeat (37) step(1'b1, 1'b0);
    check_eq("hold_x300", 32'(x0), 300);
    for (int k = 0; k < 4000 && ls0_t.size() < 3; k++) step(1'b1, 1'b1);
    check_eq("stalled_line_period", diff_at(ls0_t, 2), 3237);

    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      step(1'b1, 1'b1);
      if (x0 == 10'd400 && y0 == 10'd2) found = 1'b1;
    end
    check_eq("reach_x400", 32'(found), 1);
    step(1'b0, 1'b1);
    #1;
    check_eq("midrst_x", 32'(x0), 799);
    check_eq("midrst_y", 32'(y0), 524);
    check_eq("midrst_hsync", 32'(hs0), 1);
    check_eq("midrst_video_on", 32'(vo0), 0);
    repeat (3) step(1'b0, 1'b1);
    first_pt0 = 0;
    first_fs0 = 0;
    repeat (60) step(1'b1, 1'b1);
    check_eq("restart_first_ptick", first_pt0, 4);
    check_eq("restart_frame_start", first_fs0, 5);

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
